// File: rtl/param_stack.sv
// Parametrised LIFO stack with a registered top-of-stack view, popped-data strobe,
// occupancy flags, sticky overflow/underflow and a defined push+pop replace.
module param_stack #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             push_en,
  input  logic             pop_en,
  input  logic             clear,
  output logic [WIDTH-1:0] top,
  output logic [WIDTH-1:0] pop_data,
  output logic             pop_valid,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [CW-1:0]    count_reg, count_next;
  logic [WIDTH-1:0] top_reg, top_next;
  logic [WIDTH-1:0] pop_data_reg, pop_data_next;
  logic             pop_valid_reg, pop_valid_next;
  logic             overflow_reg, overflow_next;
  logic             underflow_reg, underflow_next;

  logic             mem_we;
  logic [AW-1:0]    mem_waddr;
  logic [AW-1:0]    idx_top;
  logic [AW-1:0]    idx_below;

  // Index arithmetic is done modulo 2**AW; results are always < DEPTH where used.
  assign idx_top   = count_reg[AW-1:0] - AW'(1);
  assign idx_below = count_reg[AW-1:0] - AW'(2);

  assign empty = (count_reg == '0);
  assign full  = (count_reg == CW'(DEPTH));

  always_comb begin
    count_next     = count_reg;
    top_next       = top_reg;
    pop_data_next  = pop_data_reg;
    pop_valid_next = 1'b0;
    overflow_next  = overflow_reg;
    underflow_next = underflow_reg;
    mem_we         = 1'b0;
    mem_waddr      = count_reg[AW-1:0];

    if (clear) begin
      count_next     = '0;
      top_next       = '0;
      overflow_next  = 1'b0;
      underflow_next = 1'b0;
    end else if (push_en && !pop_en) begin
      if (full) begin
        overflow_next = 1'b1;
      end else begin
        mem_we     = 1'b1;
        count_next = count_reg + CW'(1);
        top_next   = data_in;
      end
    end else if (pop_en && !push_en) begin
      if (empty) begin
        underflow_next = 1'b1;
      end else begin
        pop_data_next  = top_reg;
        pop_valid_next = 1'b1;
        count_next     = count_reg - CW'(1);
        // No write happens on a pop, so this array read never races a write.
        top_next       = (count_reg >= CW'(2)) ? mem[idx_below] : '0;
      end
    end else if (push_en && pop_en) begin
      pop_valid_next = 1'b1;
      if (empty) begin
        pop_data_next = data_in;
      end else begin
        pop_data_next = top_reg;
        mem_we        = 1'b1;
        mem_waddr     = idx_top;
        top_next      = data_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && mem_we) begin
      mem[mem_waddr] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg     <= '0;
      top_reg       <= '0;
      pop_data_reg  <= '0;
      pop_valid_reg <= 1'b0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      count_reg     <= count_next;
      top_reg       <= top_next;
      pop_data_reg  <= pop_data_next;
      pop_valid_reg <= pop_valid_next;
      overflow_reg  <= overflow_next;
      underflow_reg <= underflow_next;
    end
  end

  assign count     = count_reg;
  assign top       = top_reg;
  assign pop_data  = pop_data_reg;
  assign pop_valid = pop_valid_reg;
  assign overflow  = overflow_reg;
  assign underflow = underflow_reg;

endmodule

// File: tb/tb_param_stack.sv
// Scoreboard bench for param_stack: an 8x4 instance for the main scenarios and a
// 32x5 instance for the wide, non-power-of-two full boundary.
module tb_param_stack;

  logic clk;
  logic rst_n;

  logic [7:0]  a_din, a_top, a_pd;
  logic        a_push, a_pop, a_clr, a_pv, a_emp, a_ful, a_ov, a_un;
  logic [2:0]  a_cnt;

  logic [31:0] b_din, b_top, b_pd;
  logic        b_push, b_pop, b_clr, b_pv, b_emp, b_ful, b_ov, b_un;
  logic [2:0]  b_cnt;

  param_stack #(.WIDTH(8), .DEPTH(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .data_in(a_din), .push_en(a_push), .pop_en(a_pop),
    .clear(a_clr), .top(a_top), .pop_data(a_pd), .pop_valid(a_pv), .count(a_cnt),
    .empty(a_emp), .full(a_ful), .overflow(a_ov), .underflow(a_un)
  );

  param_stack #(.WIDTH(32), .DEPTH(5)) dut_b (
    .clk(clk), .rst_n(rst_n), .data_in(b_din), .push_en(b_push), .pop_en(b_pop),
    .clear(b_clr), .top(b_top), .pop_data(b_pd), .pop_valid(b_pv), .count(b_cnt),
    .empty(b_emp), .full(b_ful), .overflow(b_ov), .underflow(b_un)
  );

  typedef struct {
    string       name;
    int          dut;
    logic [31:0] top;
    logic [31:0] pd;
    logic        pv;
    int          cnt;
    logic        emp;
    logic        ful;
    logic        ov;
    logic        un;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   errors = 0;
  event async_chk;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: after every rising edge (or an asynchronous-reset probe) compare all pending expectations.
  initial begin
    forever begin
      @(posedge clk or async_chk);
      #1;
      while (expq.size() > 0) begin
        exp_t e;
        logic [31:0] at, apd;
        logic apv, aemp, aful, aov, aun;
        int acnt;
        e = expq.pop_front();
        if (e.dut == 0) begin
          at = {24'd0, a_top}; apd = {24'd0, a_pd}; apv = a_pv; acnt = int'(a_cnt);
          aemp = a_emp; aful = a_ful; aov = a_ov; aun = a_un;
        end else begin
          at = b_top; apd = b_pd; apv = b_pv; acnt = int'(b_cnt);
          aemp = b_emp; aful = b_ful; aov = b_ov; aun = b_un;
        end
        checks++;
        if ({at, apd, apv, aemp, aful, aov, aun} !== {e.top, e.pd, e.pv, e.emp, e.ful, e.ov, e.un}
            || acnt != e.cnt) begin
          errors++;
          $display("FAIL %s: got top=%h pd=%h pv=%b cnt=%0d emp=%b full=%b ov=%b un=%b; want top=%h pd=%h pv=%b cnt=%0d emp=%b full=%b ov=%b un=%b",
                   e.name, at, apd, apv, acnt, aemp, aful, aov, aun,
                   e.top, e.pd, e.pv, e.cnt, e.emp, e.ful, e.ov, e.un);
        end else begin
          $display("ok   %s: top=%h pd=%h pv=%b cnt=%0d ov=%b un=%b", e.name, at, apd, apv, acnt, aov, aun);
        end
      end
    end
  end

  function automatic exp_t mk(input int d, input string nm, input logic [31:0] etop, epd,
                              input logic epv, input int ecnt, input logic eov, eun);
    exp_t e;
    e.name = nm; e.dut = d; e.top = etop; e.pd = epd; e.pv = epv; e.cnt = ecnt;
    e.emp = (ecnt == 0); e.ful = (ecnt == ((d == 0) ? 4 : 5)); e.ov = eov; e.un = eun;
    return e;
  endfunction

  task automatic idle_inputs();
    a_push = 0; a_pop = 0; a_clr = 0; a_din = '0;
    b_push = 0; b_pop = 0; b_clr = 0; b_din = '0;
  endtask

  task automatic step(input int d, input logic ps, pp, cl, input logic [31:0] din,
                      input string nm, input logic [31:0] etop, epd, input logic epv,
                      input int ecnt, input logic eov, eun);
    @(negedge clk);
    idle_inputs();
    if (d == 0) begin
      a_push = ps; a_pop = pp; a_clr = cl; a_din = din[7:0];
    end else begin
      b_push = ps; b_pop = pp; b_clr = cl; b_din = din;
    end
    expq.push_back(mk(d, nm, etop, epd, epv, ecnt, eov, eun));
  endtask

  task automatic sa(input logic ps, pp, cl, input logic [7:0] din, input string nm,
                    input logic [7:0] etop, epd, input logic epv, input int ecnt,
                    input logic eov, eun);
    step(0, ps, pp, cl, {24'd0, din}, nm, {24'd0, etop}, {24'd0, epd}, epv, ecnt, eov, eun);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    #2;
    expq.push_back(mk(0, "reset_a", 0, 0, 0, 0, 0, 0));
    expq.push_back(mk(1, "reset_b", 0, 0, 0, 0, 0, 0));
    -> async_chk;
    @(negedge clk);
    rst_n = 1'b1;

    // push, fill, overflow, pop to empty
    sa(1, 0, 0, 8'h11, "push11", 8'h11, 8'h00, 0, 1, 0, 0);
    sa(1, 0, 0, 8'h22, "push22", 8'h22, 8'h00, 0, 2, 0, 0);
    sa(1, 0, 0, 8'h33, "push33", 8'h33, 8'h00, 0, 3, 0, 0);
    sa(1, 0, 0, 8'h44, "push44", 8'h44, 8'h00, 0, 4, 0, 0);
    sa(1, 0, 0, 8'h55, "push_full", 8'h44, 8'h00, 0, 4, 1, 0);
    sa(0, 1, 0, 8'h00, "pop44", 8'h33, 8'h44, 1, 3, 1, 0);
    sa(0, 1, 0, 8'h00, "pop33", 8'h22, 8'h33, 1, 2, 1, 0);
    sa(0, 1, 0, 8'h00, "pop22", 8'h11, 8'h22, 1, 1, 1, 0);
    sa(0, 1, 0, 8'h00, "pop11", 8'h00, 8'h11, 1, 0, 1, 0);
    sa(0, 0, 0, 8'h00, "idle_hold", 8'h00, 8'h11, 0, 0, 1, 0);

    // underflow does not block later pushes
    sa(0, 0, 1, 8'h00, "clear1", 8'h00, 8'h11, 0, 0, 0, 0);
    sa(0, 1, 0, 8'h00, "pop_empty", 8'h00, 8'h11, 0, 0, 0, 1);
    sa(1, 0, 0, 8'hA5, "pushA5", 8'hA5, 8'h11, 0, 1, 0, 1);

    // replace operations
    sa(0, 0, 1, 8'h00, "clear2", 8'h00, 8'h11, 0, 0, 0, 0);
    sa(1, 0, 0, 8'h11, "r_push11", 8'h11, 8'h11, 0, 1, 0, 0);
    sa(1, 0, 0, 8'h22, "r_push22", 8'h22, 8'h11, 0, 2, 0, 0);
    sa(1, 1, 0, 8'h99, "replace99", 8'h99, 8'h22, 1, 2, 0, 0);
    sa(0, 1, 0, 8'h00, "pop99", 8'h11, 8'h99, 1, 1, 0, 0);
    sa(1, 0, 0, 8'h22, "r_push22b", 8'h22, 8'h99, 0, 2, 0, 0);
    sa(1, 0, 0, 8'h33, "r_push33", 8'h33, 8'h99, 0, 3, 0, 0);
    sa(1, 0, 0, 8'h44, "r_push44", 8'h44, 8'h99, 0, 4, 0, 0);
    sa(1, 1, 0, 8'h66, "replace_full", 8'h66, 8'h44, 1, 4, 0, 0);
    sa(0, 1, 0, 8'h00, "pop66", 8'h33, 8'h66, 1, 3, 0, 0);
    sa(1, 1, 0, 8'h77, "replace77", 8'h77, 8'h33, 1, 3, 0, 0);
    sa(1, 0, 0, 8'h88, "push88", 8'h88, 8'h33, 0, 4, 0, 0);
    sa(0, 1, 0, 8'h00, "pop88", 8'h77, 8'h88, 1, 3, 0, 0);
    sa(0, 1, 0, 8'h00, "pop77", 8'h22, 8'h77, 1, 2, 0, 0);
    sa(0, 1, 0, 8'h00, "pop22b", 8'h11, 8'h22, 1, 1, 0, 0);
    sa(0, 1, 0, 8'h00, "pop11b", 8'h00, 8'h11, 1, 0, 0, 0);
    sa(1, 1, 0, 8'h77, "replace_empty", 8'h00, 8'h77, 1, 0, 0, 0);

    // clear overrides a simultaneous push
    sa(1, 0, 0, 8'h11, "c_push11", 8'h11, 8'h77, 0, 1, 0, 0);
    sa(1, 0, 0, 8'h22, "c_push22", 8'h22, 8'h77, 0, 2, 0, 0);
    sa(1, 0, 0, 8'h33, "c_push33", 8'h33, 8'h77, 0, 3, 0, 0);
    sa(1, 0, 0, 8'h44, "c_push44", 8'h44, 8'h77, 0, 4, 0, 0);
    sa(1, 0, 0, 8'h55, "c_push_full", 8'h44, 8'h77, 0, 4, 1, 0);
    sa(0, 1, 0, 8'h00, "c_pop44", 8'h33, 8'h44, 1, 3, 1, 0);
    sa(1, 0, 1, 8'hEE, "clear_push", 8'h00, 8'h44, 0, 0, 0, 0);

    // asynchronous reset between edges
    sa(1, 0, 0, 8'h11, "a_push11", 8'h11, 8'h44, 0, 1, 0, 0);
    sa(1, 0, 0, 8'h22, "a_push22", 8'h22, 8'h44, 0, 2, 0, 0);
    sa(1, 0, 0, 8'h33, "a_push33", 8'h33, 8'h44, 0, 3, 0, 0);
    @(negedge clk);
    idle_inputs();
    #2;
    rst_n = 1'b0;
    expq.push_back(mk(0, "async_reset", 0, 0, 0, 0, 0, 0));
    -> async_chk;
    @(negedge clk);
    rst_n = 1'b1;
    sa(1, 0, 0, 8'h5A, "push5A", 8'h5A, 8'h00, 0, 1, 0, 0);

    // 32-bit, depth 5 boundary
    for (int i = 1; i <= 5; i++)
      step(1, 1, 0, 0, 32'hA5A5_0000 + i, "b_push", 32'hA5A5_0000 + i, 0, 0, i, 0, 0);
    step(1, 1, 0, 0, 32'hDEAD_BEEF, "b_push_full", 32'hA5A5_0005, 0, 0, 5, 1, 0);
    for (int i = 5; i >= 1; i--)
      step(1, 0, 1, 0, 0, "b_pop", (i > 1) ? 32'hA5A5_0000 + (i - 1) : 32'h0,
           32'hA5A5_0000 + i, 1, i - 1, 1, 0);
    step(1, 0, 1, 0, 0, "b_pop_empty", 0, 32'hA5A5_0001, 0, 0, 1, 1);

    @(negedge clk);
    idle_inputs();
    for (int k = 0; k < 10 && expq.size() > 0; k++) @(negedge clk);
    if (expq.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations never checked, want 0", expq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
